// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared types and helpers for the Tower of Hanoi move sequencer.
//   state_e        - sequencer FSM states
//   ROD_INVALID    - out-of-range rod index driven when no move is issued
//   mod3()         - modulo-3 reduction of a zero-extended move-arithmetic operand
//   natural_target - rod the closed-form sequence lands on without relabelling
package hanoi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StMove,
        StDone
    } state_e;

    localparam logic [1:0] ROD_INVALID = 2'b11;

    // Widest move operand: N+1 bits with N <= 15.
    localparam int unsigned OPW = 16;

    function automatic logic [1:0] mod3(input logic [OPW-1:0] x);
        return 2'(x % OPW'(3));
    endfunction

    // Closed-form sequence ends on rod 1 for even N and rod 2 for odd N.
    function automatic int unsigned natural_target(input int unsigned n);
        return ((n % 2) == 0) ? 1 : 2;
    endfunction

endpackage

// File: rtl/hanoi_move_gen.sv
// hanoi_move_gen: combinational map from move index k to the (from, to) rod pair.
//   k_i    - 1-based move index (N bits)
//   from_o - source rod
//   to_o   - destination rod
// Rods 1 and 2 are relabelled when TARGET_ROD differs from the natural destination.
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DISKS = 4,
    parameter int unsigned TARGET_ROD      = 1
) (
    input  logic [NUMBER_OF_DISKS-1:0] k_i,
    output logic [1:0]                 from_o,
    output logic [1:0]                 to_o
);

    localparam int unsigned W    = NUMBER_OF_DISKS + 1;
    localparam bit          Swap = (TARGET_ROD != natural_target(NUMBER_OF_DISKS));

    function automatic logic [1:0] swap12(input logic [1:0] r);
        unique case (r)
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return r;
        endcase
    endfunction

    logic [W-1:0] k_ext;
    logic [W-1:0] k_m1;
    logic [1:0]   f_raw;
    logic [1:0]   t_raw;

    always_comb begin
        k_ext = {1'b0, k_i};
        k_m1  = k_ext - W'(1);
        // The extra bit keeps (k | (k-1)) + 1 = 2^N from wrapping on the last move.
        f_raw = mod3(OPW'(k_ext & k_m1));
        t_raw = mod3(OPW'((k_ext | k_m1) + W'(1)));
        from_o = Swap ? swap12(f_raw) : f_raw;
        to_o   = Swap ? swap12(t_raw) : t_raw;
    end

endmodule

// File: rtl/hanoi_move_sequencer.sv
// hanoi_move_sequencer: drives move_disk through an optimal 2^N-1 move solution.
//   clk_i        - clock, rising edge
//   rst_ni       - synchronous active-low reset
//   start_i      - begin (or restart) a solve; honoured in IDLE and DONE
//   hold_i       - stall issue while in MOVE
//   step_req_i   - (HANOI_SINGLE_STEP_EN only) issue at most one move per high cycle
//   dp_rst_o     - one-cycle reset strobe to move_disk
//   from_rod_o   - source rod, all-ones when no move
//   to_rod_o     - destination rod, all-ones when no move
//   move_valid_o - rod outputs carry a real move this cycle
//   move_cnt_o   - current / last issued move index (1-based)
//   busy_o       - in INIT or MOVE
//   done_o       - in DONE (sticky until restart)
// Optional feature macro: HANOI_SINGLE_STEP_EN.
module hanoi_move_sequencer
    import hanoi_pkg::*;
#(
    parameter int unsigned NUMBER_OF_RODS  = 3,
    parameter int unsigned NUMBER_OF_DISKS = 4,
    parameter int unsigned TARGET_ROD      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              hold_i,
`ifdef HANOI_SINGLE_STEP_EN
    input  logic                              step_req_i,
`endif
    output logic                              dp_rst_o,
    output logic [$clog2(NUMBER_OF_RODS)-1:0] from_rod_o,
    output logic [$clog2(NUMBER_OF_RODS)-1:0] to_rod_o,
    output logic                              move_valid_o,
    output logic [NUMBER_OF_DISKS-1:0]        move_cnt_o,
    output logic                              busy_o,
    output logic                              done_o
);

    if (NUMBER_OF_RODS != 3) begin : g_err_rods
        $error("hanoi_move_sequencer: NUMBER_OF_RODS must be 3");
    end
    if (NUMBER_OF_DISKS < 1 || NUMBER_OF_DISKS > 15) begin : g_err_disks
        $error("hanoi_move_sequencer: NUMBER_OF_DISKS must be 1..15");
    end
    if (TARGET_ROD != 1 && TARGET_ROD != 2) begin : g_err_target
        $error("hanoi_move_sequencer: TARGET_ROD must be 1 or 2");
    end

    localparam logic [NUMBER_OF_DISKS-1:0] LastK    = '1;
    localparam logic [NUMBER_OF_DISKS-1:0] FirstK   = NUMBER_OF_DISKS'(1);

    state_e                     state_q, state_d;
    logic [NUMBER_OF_DISKS-1:0] cnt_q, cnt_d;
    logic                       step_ok;
    logic                       issue;
    logic [1:0]                 gen_from;
    logic [1:0]                 gen_to;

`ifdef HANOI_SINGLE_STEP_EN
    assign step_ok = step_req_i;
`else
    assign step_ok = 1'b1;
`endif

    assign issue = (state_q == StMove) && !hold_i && step_ok;

    hanoi_move_gen #(
        .NUMBER_OF_DISKS(NUMBER_OF_DISKS),
        .TARGET_ROD     (TARGET_ROD)
    ) u_move_gen (
        .k_i   (cnt_q),
        .from_o(gen_from),
        .to_o  (gen_to)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StInit;
                    cnt_d   = FirstK;
                end
            end
            StInit: state_d = StMove;
            StMove: begin
                if (issue) begin
                    if (cnt_q == LastK) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + FirstK;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dp_rst_o     = (state_q == StInit);
        busy_o       = (state_q == StInit) || (state_q == StMove);
        done_o       = (state_q == StDone);
        move_valid_o = issue;
        move_cnt_o   = cnt_q;
        from_rod_o   = issue ? gen_from : ROD_INVALID;
        to_rod_o     = issue ? gen_to : ROD_INVALID;
    end

endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Bench for hanoi_move_sequencer: three instances (N=4/T=1, N=4/T=2, N=3/T=2).
// Stimulus pushes expected moves into per-instance queues; negedge monitors pop
// and compare whenever move_valid is high.
module tb_hanoi_move_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, start0, hold0;
    logic       rst_n1, start1;
    logic       dp_rst0, valid0, busy0, done0;
    logic [1:0] from0, to0;
    logic [3:0] cnt0;
    logic       dp_rst1, valid1, busy1, done1;
    logic [1:0] from1, to1;
    logic [3:0] cnt1;
    logic       dp_rst2, valid2, busy2, done2;
    logic [1:0] from2, to2;
    logic [2:0] cnt2;
`ifdef HANOI_SINGLE_STEP_EN
    logic       step0;
`endif

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(4), .TARGET_ROD(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n0), .start_i(start0), .hold_i(hold0),
`ifdef HANOI_SINGLE_STEP_EN
        .step_req_i(step0),
`endif
        .dp_rst_o(dp_rst0), .from_rod_o(from0), .to_rod_o(to0), .move_valid_o(valid0),
        .move_cnt_o(cnt0), .busy_o(busy0), .done_o(done0)
    );

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(4), .TARGET_ROD(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n1), .start_i(start1), .hold_i(1'b0),
`ifdef HANOI_SINGLE_STEP_EN
        .step_req_i(1'b1),
`endif
        .dp_rst_o(dp_rst1), .from_rod_o(from1), .to_rod_o(to1), .move_valid_o(valid1),
        .move_cnt_o(cnt1), .busy_o(busy1), .done_o(done1)
    );

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(3), .TARGET_ROD(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n1), .start_i(start1), .hold_i(1'b0),
`ifdef HANOI_SINGLE_STEP_EN
        .step_req_i(1'b1),
`endif
        .dp_rst_o(dp_rst2), .from_rod_o(from2), .to_rod_o(to2), .move_valid_o(valid2),
        .move_cnt_o(cnt2), .busy_o(busy2), .done_o(done2)
    );

    // Hand-solved N=4 tower to rod 1: k=1..15. N=3 to rod 2 is the first 7 entries.
    int F4 [15] = '{0, 0, 2, 0, 1, 1, 0, 0, 2, 2, 1, 2, 0, 0, 2};
    int T4 [15] = '{2, 1, 1, 2, 0, 2, 2, 1, 1, 0, 0, 1, 2, 1, 1};

    int q [3][$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int enc(input int c, input int f, input int t);
        return c * 16 + f * 4 + t;
    endfunction

    function automatic int swp(input int r);
        return (r == 1) ? 2 : (r == 2) ? 1 : r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic push_seq(input int w, input int n, input bit sw);
        for (int k = 1; k <= n; k++) begin
            q[w].push_back(enc(k, sw ? swp(F4[k-1]) : F4[k-1], sw ? swp(T4[k-1]) : T4[k-1]));
        end
    endtask

    task automatic mon(input int w, input int c, input int f, input int t);
        int e;
        if (q[w].size() == 0) begin
            n_checks++;
            $display("FAIL dut%0d unexpected move: got k=%0d %0d->%0d, required none", w, c, f, t);
        end else begin
            e = q[w].pop_front();
            chk($sformatf("dut%0d move (16k+4f+t)", w), enc(c, f, t), e);
        end
    endtask

    always @(negedge clk) if (valid0) mon(0, int'(cnt0), int'(from0), int'(to0));
    always @(negedge clk) if (valid1) mon(1, int'(cnt1), int'(from1), int'(to1));
    always @(negedge clk) if (valid2) mon(2, int'(cnt2), int'(from2), int'(to2));

    task automatic wait_cnt0(input int target);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (int'(cnt0) == target) break;
        end
        chk("u0 reach k", int'(cnt0), target);
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done0) break;
        end
        chk("u0 done", int'(done0), 1);
    endtask

    task automatic start_u0();
        @(posedge clk);
        #1 start0 = 1'b1;
        push_seq(0, 15, 1'b0);
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n0 = 1'b0; start0 = 1'b0; hold0 = 1'b0;
        rst_n1 = 1'b0; start1 = 1'b0;
`ifdef HANOI_SINGLE_STEP_EN
        step0 = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid", int'(valid0), 0);
        chk("reset from", int'(from0), 3);
        chk("reset to", int'(to0), 3);
        chk("reset cnt", int'(cnt0), 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset done", int'(done0), 0);
        chk("reset dp_rst", int'(dp_rst0), 0);
        @(posedge clk);
        #1 rst_n0 = 1'b1; rst_n1 = 1'b1;

        // u1 (N=4 to rod 2) and u2 (N=3 to rod 2) run together.
        @(posedge clk);
        #1 start1 = 1'b1;
        push_seq(1, 15, 1'b1);
        push_seq(2, 7, 1'b0);
        @(posedge clk);
        #1 start1 = 1'b0;
        chk("u2 dp_rst in INIT", int'(dp_rst2), 1);
        repeat (7) @(posedge clk);
        #1 chk("u2 done before c+9", int'(done2), 0);
        @(posedge clk);
        #1 chk("u2 done at c+9", int'(done2), 1);
        chk("u2 final cnt", int'(cnt2), 7);
        chk("u2 queue drained", q[2].size(), 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done1) break;
        end
        chk("u1 done", int'(done1), 1);
        chk("u1 queue drained", q[1].size(), 0);

        // u0 run A: start ignored mid-solve, hold at k=5.
        start_u0();
        @(negedge clk);
        chk("init dp_rst", int'(dp_rst0), 1);
        chk("init busy", int'(busy0), 1);
        chk("init valid", int'(valid0), 0);
        chk("init from", int'(from0), 3);
        wait_cnt0(3);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("start in MOVE ignored cnt", int'(cnt0), 4);
        chk("start in MOVE ignored dp_rst", int'(dp_rst0), 0);
        wait_cnt0(5);
        hold0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold valid", int'(valid0), 0);
            chk("hold from", int'(from0), 3);
            chk("hold to", int'(to0), 3);
            chk("hold cnt", int'(cnt0), 5);
            @(posedge clk);
            #1;
        end
        hold0 = 1'b0;
        wait_done0();
        chk("done busy", int'(busy0), 0);
        chk("done cnt", int'(cnt0), 15);
        chk("done valid", int'(valid0), 0);
        chk("u0 queue drained A", q[0].size(), 0);

        // Run B: restart from DONE, exact done timing.
        start_u0();
        chk("restart dp_rst", int'(dp_rst0), 1);
        chk("restart clears done", int'(done0), 0);
        repeat (15) @(posedge clk);
        #1 chk("done before c+17", int'(done0), 0);
        @(posedge clk);
        #1 chk("done at c+17", int'(done0), 1);
        chk("u0 queue drained B", q[0].size(), 0);

        // Run C: reset at k=6, then restart.
        start_u0();
        wait_cnt0(6);
        rst_n0 = 1'b0;
        @(posedge clk);
        #1 q[0].delete();
        chk("mid reset valid", int'(valid0), 0);
        chk("mid reset from", int'(from0), 3);
        chk("mid reset cnt", int'(cnt0), 0);
        chk("mid reset busy", int'(busy0), 0);
        rst_n0 = 1'b1;
        start0 = 1'b1;
        push_seq(0, 15, 1'b0);
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("post reset dp_rst", int'(dp_rst0), 1);
        wait_done0();
        chk("u0 queue drained C", q[0].size(), 0);

`ifdef HANOI_SINGLE_STEP_EN
        step0 = 1'b0;
        start_u0();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 step0 = 1'b1;
            @(posedge clk);
            #1 step0 = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("step done", int'(done0), 1);
        chk("u0 queue drained step", q[0].size(), 0);
        step0 = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
